// File: rtl/rv_pkg.sv
// Shared integer-pipeline definitions: datapath width, opcode encodings and
// the rule for which opcodes produce a destination-register result.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_BUBBLE = 7'b0000000;

    // True only for opcodes whose result is architecturally written to rd.
    function automatic logic opcode_writes_rd(input logic [6:0] opcode);
        logic writes;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_OPIMM, OPC_OP: writes = 1'b1;
            default:                     writes = 1'b0;
        endcase
        return writes;
    endfunction

endpackage

// File: rtl/regfile_bank.sv
// Architectural register storage: asynchronously cleared array with one
// synchronous write port and two raw combinational read ports.
module regfile_bank
    import rv_pkg::*;
#(
    parameter int DATA_W = rv_pkg::XLEN,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        raddr1,
    input  logic [4:0]        raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREGS];

    // Entry 0 is cleared by reset and never written, so it always reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: qualifies MEM/WB results, commits them to the register
// file, bypasses same-cycle writes to decode and tracks retirement/errors.
module wb_regfile
    import rv_pkg::*;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  wb_data_in,
    input  logic             wb_store_reg_in,
    input  logic [4:0]       wb_rd_in,
    input  logic [6:0]       wb_opcode_in,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    output logic [CNT_W-1:0] instret,
    output logic             wb_illegal,
    output logic [4:0]       last_rd
);

    logic            opc_writes;
    logic            retire;
    logic            illegal_req;
    logic            we;
    logic [XLEN-1:0] bank_rs1;
    logic [XLEN-1:0] bank_rs2;

    // Reset also masks the bypass so a write pending during reset is never seen.
    assign opc_writes  = opcode_writes_rd(wb_opcode_in);
    assign retire      = (wb_opcode_in != OPC_BUBBLE);
    assign illegal_req = wb_store_reg_in && retire && !opc_writes;
    assign we          = wb_store_reg_in && opc_writes && (wb_rd_in != 5'd0) && !rst;

    regfile_bank #(
        .DATA_W (XLEN),
        .NREGS  (NREGS)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (wb_rd_in),
        .wdata  (wb_data_in),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (bank_rs1),
        .rdata2 (bank_rs2)
    );

    always_comb begin
        rs1_data = bank_rs1;
        rs2_data = bank_rs2;
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end else if (we && rs1_addr == wb_rd_in) begin
            rs1_data = wb_data_in;
        end
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end else if (we && rs2_addr == wb_rd_in) begin
            rs2_data = wb_data_in;
        end
    end

    // Illegal and x0-destined instructions still retire; only bubbles do not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret    <= '0;
            wb_illegal <= 1'b0;
            last_rd    <= 5'd0;
        end else begin
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
            if (illegal_req) begin
                wb_illegal <= 1'b1;
            end
            if (we) begin
                last_rd <= wb_rd_in;
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: a reference model pushes expected
// commit state to a scoreboard queue that is popped after each rising edge.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_data_in;
    logic        wb_store_reg_in;
    logic [4:0]  wb_rd_in;
    logic [6:0]  wb_opcode_in;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [63:0] instret;
    logic        wb_illegal;
    logic [4:0]  last_rd;

    typedef struct {
        logic [63:0] instret;
        logic        illegal;
        logic [4:0]  last_rd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_regs [32];
    logic [63:0] m_instret;
    logic        m_illegal;
    logic [4:0]  m_last_rd;
    int          checks = 0;
    int          errors = 0;

    logic [6:0] wr_ops [7] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                               7'b0000011, 7'b0010011, 7'b0110011};

    wb_regfile dut (
        .clk             (clk),
        .rst             (rst),
        .wb_data_in      (wb_data_in),
        .wb_store_reg_in (wb_store_reg_in),
        .wb_rd_in        (wb_rd_in),
        .wb_opcode_in    (wb_opcode_in),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .instret         (instret),
        .wb_illegal      (wb_illegal),
        .last_rd         (last_rd)
    );

    always #5 clk = ~clk;

    function automatic logic model_writes(input logic [6:0] op);
        foreach (wr_ops[k]) begin
            if (wr_ops[k] == op) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        foreach (m_regs[k]) m_regs[k] = 32'd0;
        m_instret = 64'd0;
        m_illegal = 1'b0;
        m_last_rd = 5'd0;
        sb.delete();
    endtask

    // Drives one MEM/WB instruction on a falling edge and records its expected outcome.
    task automatic drive(input logic [6:0] op, input logic st, input logic [4:0] rd,
                         input logic [31:0] data);
        exp_t e;
        logic w;
        @(negedge clk);
        wb_opcode_in    = op;
        wb_store_reg_in = st;
        wb_rd_in        = rd;
        wb_data_in      = data;
        w = model_writes(op);
        if (op != 7'd0) m_instret = m_instret + 64'd1;
        if (st && w && rd != 5'd0) begin
            m_regs[rd] = data;
            m_last_rd  = rd;
        end
        if (st && op != 7'd0 && !w) m_illegal = 1'b1;
        e.instret = m_instret;
        e.illegal = m_illegal;
        e.last_rd = m_last_rd;
        sb.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        wb_opcode_in    = 7'd0;
        wb_store_reg_in = 1'b0;
        wb_rd_in        = 5'd0;
        wb_data_in      = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        model_reset();
        idle();
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            #1;
            checks++;
            if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
                errors++;
                $display("[TB] FAIL reset_read x%0d got rs1=%h rs2=%h expected 0", i, rs1_data, rs2_data);
            end
        end
        checks++;
        if (instret !== 64'd0 || wb_illegal !== 1'b0 || last_rd !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_state got instret=%0d illegal=%b last_rd=%0d expected 0/0/0",
                     instret, wb_illegal, last_rd);
        end
    endtask

    task automatic test_basic_commit();
        exp_t e;
        drive(7'b0110011, 1'b1, 5'd5, 32'hDEADBEEF);
        settle();
        e = sb.pop_front();
        checks++;
        if (instret !== e.instret || last_rd !== e.last_rd || wb_illegal !== e.illegal) begin
            errors++;
            $display("[TB] FAIL basic_state got %0d/%0d/%b expected %0d/%0d/%b",
                     instret, last_rd, wb_illegal, e.instret, e.last_rd, e.illegal);
        end
        idle();
        rs1_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data !== m_regs[5]) begin
            errors++;
            $display("[TB] FAIL basic_read got %h expected %h", rs1_data, m_regs[5]);
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        drive(7'b0110011, 1'b1, 5'd7, 32'h11111111);
        settle();
        void'(sb.pop_front());
        drive(7'b0000011, 1'b1, 5'd7, 32'h12345678);
        rs1_addr = 5'd7;
        rs2_addr = 5'd7;
        #1;
        checks++;
        if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL bypass got rs1=%h rs2=%h expected 12345678", rs1_data, rs2_data);
        end
        rs2_addr = 5'd5;
        #1;
        checks++;
        if (rs2_data !== m_regs[5]) begin
            errors++;
            $display("[TB] FAIL bypass_other got %h expected %h", rs2_data, m_regs[5]);
        end
        settle();
        e = sb.pop_front();
        checks++;
        if (instret !== e.instret || last_rd !== e.last_rd) begin
            errors++;
            $display("[TB] FAIL bypass_commit got %0d/%0d expected %0d/%0d",
                     instret, last_rd, e.instret, e.last_rd);
        end
    endtask

    task automatic test_x0_bubble();
        exp_t e;
        drive(7'b0010011, 1'b1, 5'd0, 32'hFFFFFFFF);
        rs1_addr = 5'd0;
        #1;
        checks++;
        if (rs1_data !== 32'd0) begin
            errors++;
            $display("[TB] FAIL x0_read got %h expected 0", rs1_data);
        end
        settle();
        e = sb.pop_front();
        checks++;
        if (instret !== e.instret || last_rd !== e.last_rd || wb_illegal !== e.illegal) begin
            errors++;
            $display("[TB] FAIL x0_state got %0d/%0d/%b expected %0d/%0d/%b",
                     instret, last_rd, wb_illegal, e.instret, e.last_rd, e.illegal);
        end
        drive(7'b0000000, 1'b1, 5'd9, 32'h55555555);
        rs1_addr = 5'd9;
        #1;
        checks++;
        if (rs1_data !== m_regs[9]) begin
            errors++;
            $display("[TB] FAIL bubble_bypass got %h expected %h", rs1_data, m_regs[9]);
        end
        settle();
        e = sb.pop_front();
        checks++;
        if (instret !== e.instret || wb_illegal !== e.illegal || last_rd !== e.last_rd) begin
            errors++;
            $display("[TB] FAIL bubble_state got %0d/%b/%0d expected %0d/%b/%0d",
                     instret, wb_illegal, last_rd, e.instret, e.illegal, e.last_rd);
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        drive(7'b0010011, 1'b1, 5'd3, 32'h33333333);
        settle();
        void'(sb.pop_front());
        drive(7'b0100011, 1'b1, 5'd3, 32'hAAAA5555);
        rs1_addr = 5'd3;
        #1;
        checks++;
        if (rs1_data !== m_regs[3]) begin
            errors++;
            $display("[TB] FAIL illegal_bypass got %h expected %h", rs1_data, m_regs[3]);
        end
        settle();
        for (int n = 0; n < 11; n++) begin
            e = sb.pop_front();
            checks++;
            if (wb_illegal !== e.illegal || instret !== e.instret || last_rd !== e.last_rd) begin
                errors++;
                $display("[TB] FAIL illegal_sticky step %0d got %b/%0d/%0d expected %b/%0d/%0d",
                         n, wb_illegal, instret, last_rd, e.illegal, e.instret, e.last_rd);
            end
            if (n < 10) begin
                drive(wr_ops[$urandom_range(6)], 1'b1, 5'($urandom_range(4, 31)), $urandom);
                settle();
            end
        end
        idle();
        rs1_addr = 5'd3;
        #1;
        checks++;
        if (rs1_data !== m_regs[3]) begin
            errors++;
            $display("[TB] FAIL illegal_x3 got %h expected %h", rs1_data, m_regs[3]);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int n = 0; n < 16; n++) begin
            drive(wr_ops[$urandom_range(6)], 1'($urandom_range(3) != 0),
                  5'($urandom_range(31)), $urandom);
            settle();
            e = sb.pop_front();
            checks++;
            if (instret !== e.instret || last_rd !== e.last_rd || wb_illegal !== e.illegal) begin
                errors++;
                $display("[TB] FAIL b2b_state %0d got %0d/%0d/%b expected %0d/%0d/%b",
                         n, instret, last_rd, wb_illegal, e.instret, e.last_rd, e.illegal);
            end
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(i);
            #1;
            checks++;
            if (rs1_data !== m_regs[i] || rs2_data !== m_regs[i]) begin
                errors++;
                $display("[TB] FAIL b2b_read x%0d got %h/%h expected %h", i, rs1_data, rs2_data, m_regs[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        wb_opcode_in    = 7'b1101111;
        wb_store_reg_in = 1'b1;
        wb_rd_in        = 5'd1;
        wb_data_in      = 32'hCAFE0001;
        rs1_addr        = 5'd1;
        rs2_addr        = 5'd2;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (rs1_data !== 32'd0 || rs2_data !== 32'd0 || instret !== 64'd0) begin
            errors++;
            $display("[TB] FAIL async_reset got x1=%h x2=%h instret=%0d expected 0/0/0",
                     rs1_data, rs2_data, instret);
        end
        checks++;
        if (wb_illegal !== 1'b0 || last_rd !== 5'd0) begin
            errors++;
            $display("[TB] FAIL async_reset_flags got %b/%0d expected 0/0", wb_illegal, last_rd);
        end
        settle();
        checks++;
        if (rs1_data !== 32'd0 || instret !== 64'd0) begin
            errors++;
            $display("[TB] FAIL reset_hold got x1=%h instret=%0d expected 0/0", rs1_data, instret);
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        rst             = 1'b1;
        wb_data_in      = 32'd0;
        wb_store_reg_in = 1'b0;
        wb_rd_in        = 5'd0;
        wb_opcode_in    = 7'd0;
        rs1_addr        = 5'd0;
        rs2_addr        = 5'd0;
        model_reset();
        test_reset();
        test_basic_commit();
        test_bypass();
        test_x0_bubble();
        test_illegal();
        test_back_to_back();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback end of the integer pipeline: consumes the MEM/WB register outputs (result data, write-enable flag, destination register, opcode) and commits results into the 32x32 architectural register file.
- Provides two combinational read ports to decode, with same-cycle writeback bypass.
- Maintains a retired-instruction counter and a sticky flag for illegal writeback requests.

Parameters:
- XLEN, 32, register and data width.
- NREGS, 32, number of architectural registers; x0 is hardwired zero.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; commits occur on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- wb_data_in  input  XLEN  result from MEM/WB register.
- wb_store_reg_in  input  1  MEM/WB write-enable request.
- wb_rd_in  input  5  destination register index.
- wb_opcode_in  input  7  opcode of the instruction in writeback; 7'b0000000 marks a bubble.
- rs1_addr  input  5  read port 1 index.
- rs2_addr  input  5  read port 2 index.
- rs1_data  output  XLEN  read port 1 data, combinational.
- rs2_data  output  XLEN  read port 2 data, combinational.
- instret  output  CNT_W  count of retired (non-bubble) instructions.
- wb_illegal  output  1  sticky error flag.
- last_rd  output  5  index of the last register actually written.

Behaviour:
- Reset: asynchronous on rst high. Clears:
  - all registers x1..x31 to 0;
  - instret to 0;
  - wb_illegal to 0;
  - last_rd to 0.
  - Reset asserted mid-operation discards any write pending that cycle.
- MEM/WB inputs change on falling edges. This block samples them on the following rising edge, so results commit half a cycle after MEM/WB updates.
- Write-enable qualification: `we = wb_store_reg_in && opcode_writes && wb_rd_in != 0`.
  - `opcode_writes` is true for these opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP 0110011.
- Commit on rising edge when we: `reg[wb_rd_in] <= wb_data_in` and `last_rd <= wb_rd_in`.
- Writes to x0 are silently dropped. They are not illegal and do not update last_rd.
- Illegal request: wb_store_reg_in=1 with a non-bubble opcode outside the writing set (STORE 0100011, BRANCH 1100011, SYSTEM, or unknown).
  - The write is suppressed.
  - wb_illegal is set at that edge and stays at 1 until reset.
- Bubble: opcode 0000000. No write and no count, regardless of wb_store_reg_in; this is never illegal.
- instret: increments by 1 on every rising edge whose opcode is non-bubble, including illegal and x0-destined instructions. Wraps modulo 2^CNT_W with no flag.
- Read ports: purely combinational.
  - Address 0 returns 0.
  - Else, if we is true and the address equals wb_rd_in, return wb_data_in (bypass).
  - Else return the stored value.
- Both read ports may address the same register, including the one being bypassed.

Decomposition:
- Shared package rv_pkg holds:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP, OPC_STORE, OPC_BRANCH, OPC_SYSTEM, OPC_BUBBLE);
  - XLEN;
  - a function opcode_writes_rd(opcode).
- One sub-module, regfile_bank: storage array, async clear, one write port and two raw read ports.
- Bypass, qualification, counter and flag live in wb_regfile.

Test Plan:
1. Reset then read all: assert rst, release, read x0..x31 → every rs1_data/rs2_data = 0, instret=0, wb_illegal=0.
2. Basic commit: OP, store_reg=1, rd=5, data=0xDEADBEEF; after the rising edge read rs1_addr=5 → 0xDEADBEEF, last_rd=5, instret=1.
3. Bypass: during the same cycle as a LOAD writing rd=7 data=0x12345678, set rs1_addr=7, rs2_addr=7 → both ports return 0x12345678 before the edge. An old value in x7 is not visible.
4. x0 and bubbles:
   - OP-IMM rd=0 data=0xFFFFFFFF → x0 reads 0, last_rd unchanged, instret+1.
   - opcode 0 with store_reg=1 → no write, instret unchanged, wb_illegal=0.
5. Illegal: STORE opcode, store_reg=1, rd=3, data=0xAAAA5555 → x3 unchanged, wb_illegal=1. It stays 1 through 10 further legal instructions until rst.
6. Async reset mid-stream: pulse rst between edges while a JAL to rd=1 is pending → x1 reads 0, instret=0 immediately, without waiting for a clock edge.
